// File: rtl/weight_sha_packer.sv
// Packs 128-bit weight beats into SHA-256-padded 512-bit blocks; block valid one cycle after the completing beat.
// Backpressure: s_ready only while filling, so no beat is taken in a cycle where a block is presented or consumed.
module weight_sha_packer #(
  parameter int AXI_WIDTH   = 128,
  parameter int BLOCK_WIDTH = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AXI_WIDTH-1:0]   s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [BLOCK_WIDTH-1:0] m_block,
  output logic                   m_valid,
  output logic                   m_first,
  output logic                   m_last,
  input  logic                   m_ready
);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] OUT  = 2'd1;
  localparam logic [1:0] PAD  = 2'd2;

  logic [1:0]             state;
  logic [1:0]             cnt;
  logic [63:0]            len;
  logic [63:0]            len_inc;
  logic                   pad_pending;
  logic                   beat_acc;
  logic                   blk_acc;
  logic [BLOCK_WIDTH-1:0] fill_block;

  assign s_ready  = (state == FILL) && !rst;
  assign m_valid  = (state != FILL) && !rst;
  assign beat_acc = s_valid && s_ready;
  assign blk_acc  = m_valid && m_ready;
  assign len_inc  = len + 64'd128;

  // Block image after writing the current beat; a short final beat also gets its padding and length.
  always_comb begin
    fill_block = m_block;
    fill_block[BLOCK_WIDTH-1 - AXI_WIDTH*int'(cnt) -: AXI_WIDTH] = s_data;
    if (s_last) begin
      if (cnt == 2'd0)      fill_block[383:0] = {8'h80, 312'b0, len_inc};
      else if (cnt == 2'd1) fill_block[255:0] = {8'h80, 184'b0, len_inc};
      else if (cnt == 2'd2) fill_block[127:0] = {8'h80, 56'b0, len_inc};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      cnt         <= 2'd0;
      len         <= 64'd0;
      pad_pending <= 1'b0;
      m_last      <= 1'b0;
      m_first     <= 1'b1;
      m_block     <= '0;
    end else begin
      case (state)
        FILL: begin
          if (beat_acc) begin
            m_block <= fill_block;
            len     <= len_inc;
            if (s_last) begin
              state       <= OUT;
              m_last      <= (cnt != 2'd3);
              pad_pending <= (cnt == 2'd3);
            end else if (cnt == 2'd3) begin
              state  <= OUT;
              m_last <= 1'b0;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        OUT: begin
          if (blk_acc) begin
            cnt <= 2'd0;
            if (pad_pending) begin
              m_block <= {8'h80, 440'b0, len};
              m_first <= 1'b0;
              m_last  <= 1'b1;
              state   <= PAD;
            end else begin
              // Cleared so the next block starts with no stale slot data.
              m_block <= '0;
              m_last  <= 1'b0;
              state   <= FILL;
              if (m_last) begin
                len     <= 64'd0;
                m_first <= 1'b1;
              end else begin
                m_first <= 1'b0;
              end
            end
          end
        end
        PAD: begin
          if (blk_acc) begin
            len         <= 64'd0;
            pad_pending <= 1'b0;
            m_first     <= 1'b1;
            m_last      <= 1'b0;
            m_block     <= '0;
            state       <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
